// File: rtl/matrix_display_reader_if.sv
// rtl/matrix_display_reader_if.sv - display request, store read port and byte stream bundle
interface matrix_display_reader_if;
    logic       disp_req;
    logic [3:0] disp_id;
    logic [2:0] disp_m;
    logic [2:0] disp_n;
    logic       start_disp;
    logic [3:0] matrix_id_sel;
    logic       read_en;
    logic [7:0] data_out;
    logic       meta_info_valid;
    logic       error_flag;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        input  disp_req, disp_id, disp_m, disp_n,
        input  data_out, meta_info_valid, error_flag, tx_ready,
        output start_disp, matrix_id_sel, read_en,
        output tx_data, tx_valid, busy, done, err
    );

    modport slave (
        output disp_req, disp_id, disp_m, disp_n,
        output data_out, meta_info_valid, error_flag, tx_ready,
        input  start_disp, matrix_id_sel, read_en,
        input  tx_data, tx_valid, busy, done, err
    );
endinterface

// File: rtl/matrix_display_reader.sv
// rtl/matrix_display_reader.sv - walks a stored matrix and streams it as ASCII decimal rows
module matrix_display_reader #(
    parameter int SETTLE       = 2,
    parameter int META_TIMEOUT = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    matrix_display_reader_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_META,
        S_SETTLE,
        S_FORMAT,
        S_SEND_DIG,
        S_SEND_SEP,
        S_ADVANCE,
        S_DONE,
        S_ABORT
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [3:0] META_LAST   = 4'(META_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [3:0] id_q, id_d;
    logic [2:0] m_q, m_d;
    logic [2:0] n_q, n_d;
    logic [2:0] row_q, row_d;
    logic [2:0] col_q, col_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] elem_q, elem_d;
    logic [1:0] pos_q, pos_d;

    logic [7:0] hund, tens, units, digit;
    logic       last_col, last_row, bad_dims;

    logic       start_disp_c, read_en_c, tx_valid_c, busy_c, done_c, err_c;
    logic [7:0] tx_data_c;

    // Decimal split of the latched element; pos selects the digit being sent
    always_comb begin
        hund  = elem_q / 8'd100;
        tens  = (elem_q / 8'd10) % 8'd10;
        units = elem_q % 8'd10;
        case (pos_q)
            2'd0:    digit = hund;
            2'd1:    digit = tens;
            default: digit = units;
        endcase
    end

    assign last_col = (col_q == n_q - 3'd1);
    assign last_row = (row_q == m_q - 3'd1);
    assign bad_dims = (bus.disp_m == 3'd0) || (bus.disp_m > 3'd5) ||
                      (bus.disp_n == 3'd0) || (bus.disp_n > 3'd5);

    // Next-state and Moore outputs; every output is a function of the registered state
    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        m_d          = m_q;
        n_d          = n_q;
        row_d        = row_q;
        col_d        = col_q;
        cnt_d        = cnt_q;
        elem_d       = elem_q;
        pos_d        = pos_q;
        start_disp_c = 1'b0;
        read_en_c    = 1'b0;
        tx_valid_c   = 1'b0;
        tx_data_c    = 8'h00;
        busy_c       = 1'b0;
        done_c       = 1'b0;
        err_c        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.disp_req) begin
                    id_d    = bus.disp_id;
                    m_d     = bus.disp_m;
                    n_d     = bus.disp_n;
                    state_d = bad_dims ? S_ABORT : S_REQ;
                end
            end
            S_REQ: begin
                busy_c       = 1'b1;
                start_disp_c = 1'b1;
                cnt_d        = 4'd0;
                row_d        = 3'd0;
                col_d        = 3'd0;
                state_d      = S_WAIT_META;
            end
            S_WAIT_META: begin
                busy_c = 1'b1;
                // error_flag takes priority over a simultaneous meta_info_valid
                if (bus.error_flag) begin
                    state_d = S_ABORT;
                end else if (bus.meta_info_valid) begin
                    cnt_d   = 4'd0;
                    state_d = S_SETTLE;
                end else if (cnt_q == META_LAST) begin
                    state_d = S_ABORT;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_SETTLE: begin
                busy_c = 1'b1;
                if (cnt_q == SETTLE_LAST) begin
                    elem_d  = bus.data_out;
                    state_d = S_FORMAT;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_FORMAT: begin
                busy_c = 1'b1;
                // Skip leading zeros; zero itself still sends its units digit
                if (elem_q >= 8'd100) begin
                    pos_d = 2'd0;
                end else if (elem_q >= 8'd10) begin
                    pos_d = 2'd1;
                end else begin
                    pos_d = 2'd2;
                end
                state_d = S_SEND_DIG;
            end
            S_SEND_DIG: begin
                busy_c     = 1'b1;
                tx_valid_c = 1'b1;
                tx_data_c  = 8'h30 + digit;
                if (bus.tx_ready) begin
                    if (pos_q == 2'd2) begin
                        pos_d   = 2'd0;
                        state_d = S_SEND_SEP;
                    end else begin
                        pos_d = pos_q + 2'd1;
                    end
                end
            end
            S_SEND_SEP: begin
                busy_c     = 1'b1;
                tx_valid_c = 1'b1;
                if (!last_col) begin
                    tx_data_c = 8'h20;
                    if (bus.tx_ready) begin
                        state_d = S_ADVANCE;
                    end
                end else if (pos_q == 2'd0) begin
                    tx_data_c = 8'h0D;
                    if (bus.tx_ready) begin
                        pos_d = 2'd1;
                    end
                end else begin
                    tx_data_c = 8'h0A;
                    if (bus.tx_ready) begin
                        state_d = S_ADVANCE;
                    end
                end
            end
            S_ADVANCE: begin
                busy_c    = 1'b1;
                read_en_c = 1'b1;
                cnt_d     = 4'd0;
                pos_d     = 2'd0;
                if (last_col) begin
                    col_d = 3'd0;
                    if (last_row) begin
                        state_d = S_DONE;
                    end else begin
                        row_d   = row_q + 3'd1;
                        state_d = S_SETTLE;
                    end
                end else begin
                    col_d   = col_q + 3'd1;
                    state_d = S_SETTLE;
                end
            end
            S_DONE: begin
                done_c  = 1'b1;
                state_d = S_IDLE;
            end
            S_ABORT: begin
                err_c   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            id_q    <= 4'd0;
            m_q     <= 3'd0;
            n_q     <= 3'd0;
            row_q   <= 3'd0;
            col_q   <= 3'd0;
            cnt_q   <= 4'd0;
            elem_q  <= 8'd0;
            pos_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            m_q     <= m_d;
            n_q     <= n_d;
            row_q   <= row_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            elem_q  <= elem_d;
            pos_q   <= pos_d;
        end
    end

    assign bus.start_disp    = start_disp_c;
    assign bus.matrix_id_sel = id_q;
    assign bus.read_en       = read_en_c;
    assign bus.tx_data       = tx_data_c;
    assign bus.tx_valid      = tx_valid_c;
    assign bus.busy          = busy_c;
    assign bus.done          = done_c;
    assign bus.err           = err_c;
endmodule

// File: tb/tb_matrix_display_reader.sv
// tb/tb_matrix_display_reader.sv - directed and randomized checks against a behavioural model
module tb_matrix_display_reader;
    logic clk;
    logic rst_n;

    matrix_display_reader_if bus ();

    matrix_display_reader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    int cyc = 0;
    int rd_cnt, start_cnt, err_cnt, done_cnt, stab_bad;
    int err_cyc, start_cyc, req_cyc;
    int idx, junk, pend, st_mode;
    bit ready_rand, req_pending, stall_prev;
    logic [7:0] prev_data;
    logic [3:0] sel_seen;
    logic [7:0] mat [25];
    logic [7:0] got [$];
    logic [7:0] expq [$];

    task automatic check(input string tag, input int obs, input int expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    // One clock of the store/UART environment, evaluated mid-cycle
    task automatic step();
        @(negedge clk);
        cyc++;
        if (junk > 0) junk--;
        bus.meta_info_valid = 1'b0;
        bus.error_flag      = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                if (st_mode == 1 || st_mode == 3) bus.error_flag = 1'b1;
                if (st_mode == 0 || st_mode == 3) begin
                    bus.meta_info_valid = 1'b1;
                    junk = 2;
                end
            end
        end
        if (bus.start_disp) begin
            start_cnt++;
            start_cyc = cyc;
            sel_seen  = bus.matrix_id_sel;
            idx       = 0;
            if (st_mode == 0) pend = 1 + int'($urandom_range(0, 3));
            else if (st_mode != 2) pend = 1;
        end
        if (bus.read_en) begin
            rd_cnt++;
            idx++;
            junk = 2;
        end
        if (bus.err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (bus.done) done_cnt++;
        bus.disp_req = req_pending;
        if (req_pending) req_cyc = cyc;
        req_pending = 1'b0;
        bus.tx_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.data_out = (junk > 0) ? 8'hEE : mat[(idx < 25) ? idx : 0];
        if (stall_prev && (!bus.tx_valid || bus.tx_data !== prev_data)) stab_bad++;
        stall_prev = bus.tx_valid && !bus.tx_ready;
        prev_data  = bus.tx_data;
        if (bus.tx_valid && bus.tx_ready) got.push_back(bus.tx_data);
    endtask

    task automatic run_xfer(input logic [3:0] id, input logic [2:0] m, input logic [2:0] n,
                            input int mode, input bit rnd, input int extra_at, input int budget);
        got.delete();
        rd_cnt = 0; start_cnt = 0; err_cnt = 0; done_cnt = 0; stab_bad = 0;
        err_cyc = -1; start_cyc = -1; req_cyc = -1;
        idx = 0; junk = 0; pend = 0; stall_prev = 1'b0;
        sel_seen = 4'd0;
        st_mode = mode;
        ready_rand = rnd;
        bus.disp_id = id;
        bus.disp_m  = m;
        bus.disp_n  = n;
        req_pending = 1'b1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (i == extra_at) req_pending = 1'b1;
            if (done_cnt + err_cnt > 0) break;
        end
        step();
        step();
    endtask

    // Expected text: decimal values, space between columns, CR LF after each row
    task automatic build_exp(input int m, input int n);
        string s;
        expq.delete();
        for (int r = 0; r < m; r++) begin
            for (int c = 0; c < n; c++) begin
                s = $sformatf("%0d", mat[r * n + c]);
                for (int k = 0; k < s.len(); k++) expq.push_back(s[k]);
                if (c < n - 1) expq.push_back(8'h20);
                else begin
                    expq.push_back(8'h0D);
                    expq.push_back(8'h0A);
                end
            end
        end
    endtask

    task automatic check_bytes(input string tag);
        int bad;
        bad = 0;
        check({tag, "_len"}, got.size(), expq.size());
        for (int i = 0; i < got.size() && i < expq.size(); i++)
            if (got[i] !== expq[i]) bad++;
        check({tag, "_bytes"}, bad, 0);
    endtask

    task automatic fill_random(input int cnt);
        for (int i = 0; i < cnt; i++) mat[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic check_idle_outputs(input string tag);
        check(tag, int'({bus.busy, bus.done, bus.err, bus.start_disp, bus.read_en,
                         bus.tx_valid, bus.tx_data, bus.matrix_id_sel}), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.disp_req = 1'b0; bus.disp_id = 4'd0; bus.disp_m = 3'd0; bus.disp_n = 3'd0;
        bus.data_out = 8'd0; bus.meta_info_valid = 1'b0; bus.error_flag = 1'b0;
        bus.tx_ready = 1'b0;
        idx = 0; junk = 0; pend = 0; st_mode = 2; ready_rand = 1'b0;
        req_pending = 1'b0; stall_prev = 1'b0;
        for (int i = 0; i < 25; i++) mat[i] = 8'd0;
        step(); step();
        check_idle_outputs("reset_outputs");
        @(negedge clk) rst_n = 1'b1;

        // 2x3, values 1..6, ready always high
        for (int i = 0; i < 6; i++) mat[i] = 8'(i + 1);
        build_exp(2, 3);
        run_xfer(4'd1, 3'd2, 3'd3, 0, 1'b0, -1, 400);
        check_bytes("m2x3");
        check("m2x3_read_en", rd_cnt, 6);
        check("m2x3_done", done_cnt, 1);
        check("m2x3_err", err_cnt, 0);
        check("m2x3_sel", int'(sel_seen), 1);
        check("m2x3_busy_after", int'(bus.busy), 0);

        // 1x1 holding zero
        mat[0] = 8'd0;
        build_exp(1, 1);
        run_xfer(4'd3, 3'd1, 3'd1, 0, 1'b0, -1, 200);
        check_bytes("m1x1_zero");
        check("m1x1_read_en", rd_cnt, 1);

        // 1x2 holding 10 and 255
        mat[0] = 8'd10; mat[1] = 8'd255;
        build_exp(1, 2);
        run_xfer(4'd4, 3'd1, 3'd2, 0, 1'b0, -1, 200);
        check_bytes("m1x2");
        check("m1x2_done", done_cnt, 1);

        // Illegal dimensions
        run_xfer(4'd2, 3'd0, 3'd3, 0, 1'b0, -1, 20);
        check("m0_err_latency", err_cyc - req_cyc, 1);
        check("m0_no_start", start_cnt, 0);
        run_xfer(4'd2, 3'd2, 3'd6, 0, 1'b0, -1, 20);
        check("n6_err_latency", err_cyc - req_cyc, 1);
        check("n6_no_start", start_cnt, 0);

        // Store rejects in the cycle after start_disp
        run_xfer(4'd5, 3'd2, 3'd2, 1, 1'b0, -1, 40);
        check("rej_err", err_cnt, 1);
        check("rej_tx", got.size(), 0);
        check("rej_read_en", rd_cnt, 0);

        // Store silent: timeout counted from entry to the wait state
        run_xfer(4'd6, 3'd2, 3'd2, 2, 1'b0, -1, 40);
        check("tmo_err", err_cnt, 1);
        check("tmo_latency", err_cyc - start_cyc, 9);
        check("tmo_read_en", rd_cnt, 0);

        // meta_info_valid and error_flag together: error wins
        run_xfer(4'd8, 3'd2, 3'd2, 3, 1'b0, -1, 40);
        check("both_err", err_cnt, 1);
        check("both_read_en", rd_cnt, 0);
        check("both_tx", got.size(), 0);

        // 5x5 random values, random back-pressure, extra request while busy
        fill_random(25);
        build_exp(5, 5);
        run_xfer(4'd9, 3'd5, 3'd5, 0, 1'b1, 20, 3000);
        check_bytes("m5x5");
        check("m5x5_read_en", rd_cnt, 25);
        check("m5x5_stable", stab_bad, 0);
        check("m5x5_one_start", start_cnt, 1);
        check("m5x5_done", done_cnt, 1);

        // Reset mid-stream, then a fresh transfer
        fill_random(25);
        run_xfer(4'd7, 3'd5, 3'd5, 0, 1'b1, -1, 60);
        check("mid_busy", int'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_reset_outputs");
        step(); step();
        @(negedge clk) rst_n = 1'b1;
        fill_random(4);
        build_exp(2, 2);
        run_xfer(4'd10, 3'd2, 3'd2, 0, 1'b1, -1, 800);
        check_bytes("post_reset");
        check("post_reset_read_en", rd_cnt, 4);
        check("post_reset_done", done_cnt, 1);
        check("post_reset_sel", int'(sel_seen), 10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/matrix_display_reader.md
Name: matrix_display_reader

Overview:
- Reader side of the matrix store's display port.
- On a display request it issues start_disp and the matrix ID to the store, then steps through every element with read_en.
- Each element is converted to ASCII decimal and streamed as a byte over a valid/ready interface toward the UART transmitter.
- Row layout: elements separated by one space; each row ends with CR (0x0D) LF (0x0A).

Parameters:
- SETTLE, 2, cycles from meta_info_valid or read_en until data_out is stable for sampling.
- META_TIMEOUT, 8, cycles to wait for meta_info_valid before aborting.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- disp_req  input  1  one-cycle request pulse; ignored while busy
- disp_id  input  4  matrix ID to display, sampled with disp_req
- disp_m  input  3  row count of the selected matrix (1..5), sampled with disp_req
- disp_n  input  3  column count of the selected matrix (1..5), sampled with disp_req
- start_disp  output  1  one-cycle pulse to the store
- matrix_id_sel  output  4  ID presented to the store's matrix_id_in; held for the whole transfer
- read_en  output  1  one-cycle pulse that advances the store's read index
- data_out  input  8  element value from the store
- meta_info_valid  input  1  store acknowledges the display start
- error_flag  input  1  store rejects the request
- tx_data  output  8  ASCII byte
- tx_valid  output  1  byte valid; held until tx_ready
- tx_ready  input  1  downstream accepts the byte this cycle
- busy  output  1  high from request acceptance until done or err
- done  output  1  one-cycle pulse after the last LF is accepted
- err  output  1  one-cycle pulse on abort

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n). Reset drives every output to 0 and the FSM to IDLE. Reset mid-transfer abandons the transfer silently.
- IDLE:
  - A disp_req pulse latches disp_id, disp_m and disp_n.
  - If disp_m or disp_n is 0 or greater than 5: pulse err the next cycle, issue nothing to the store, return to IDLE.
  - Otherwise assert busy and go to REQ.
- REQ: start_disp=1 for exactly one cycle; matrix_id_sel=disp_id. Go to WAIT_META.
- WAIT_META:
  - meta_info_valid goes to SETTLE.
  - error_flag, or META_TIMEOUT cycles without meta_info_valid, goes to ABORT.
  - If meta_info_valid and error_flag arrive in the same cycle, error_flag wins.
- SETTLE: count SETTLE cycles, then register data_out into elem and go to FORMAT.
- FORMAT: split elem into hundreds, tens and units digits, each 0..9. Leading zeros are suppressed; the value 0 emits the single digit "0". Digit count is 1 to 3.
- SEND_DIG:
  - Present 0x30+digit on tx_data with tx_valid=1.
  - Advance on the cycle where tx_valid and tx_ready are both high.
  - tx_data must not change while tx_valid is high and tx_ready is low.
- SEND_SEP:
  - Column < n-1: send one space (0x20).
  - Last column: send CR, then LF.
- ADVANCE:
  - Pulse read_en for one cycle, after every element including the last, so the store's read cycle completes. Exactly m*n read_en pulses per transfer.
  - Increment column; at n-1, wrap column to 0 and increment row.
  - If the element just sent was the last (row=m-1, column=n-1): go to DONE. Otherwise go to SETTLE.
- DONE: pulse done, clear busy, return to IDLE.
- ABORT: pulse err, clear busy, return to IDLE. Any byte already handshaken stays sent; no partial byte is left with tx_valid high.
- Counters:
  - Row and column counters are 3 bits.
  - Element count maximum is 25.
  - Byte count per matrix maximum is 25*3 + 25 separators + 5 extra for CRLF; no counter is needed for it.
- Pacing and requests: tx_ready held low indefinitely stalls the FSM with no timeout. disp_req while busy is dropped.

Test Plan:
- Matrix 2x3 with ID 1 holding 1,2,3,4,5,6; tx_ready tied high -> bytes "1 2 3\r\n4 5 6\r\n"; 6 read_en pulses; done pulse; busy low afterwards.
- Matrix 1x1 with value 0 -> bytes "0\r\n". Matrix 1x2 with values 10,255 -> "10 255\r\n".
- disp_m=0 or disp_n=6 -> err the next cycle; start_disp never asserted.
- Store raises error_flag in the cycle after start_disp -> err pulse; no tx bytes; no read_en.
- Store never answers -> err exactly META_TIMEOUT=8 cycles after entering WAIT_META.
- tx_ready toggling randomly on a 5x5 matrix -> tx_data stable while stalled; 25 read_en pulses; byte stream matches the reference model.
- Reset asserted mid-stream -> all outputs 0; a fresh disp_req afterwards completes normally.
